// File: rtl/mpu_poll_sequencer_if.sv
// Request/response bundle between the poll sequencer and the MPU-6050
// I2C controller (top_mpu_6050).
interface mpu_poll_sequencer_if;
  logic        O_EN;
  logic [7:0]  O_INSTR;
  logic        I_BUSY;
  logic        I_ERR;
  logic [23:0] I_RXD;

  modport master (
    output O_EN, O_INSTR,
    input  I_BUSY, I_ERR, I_RXD
  );

  modport slave (
    input  O_EN, O_INSTR,
    output I_BUSY, I_ERR, I_RXD
  );
endinterface

// File: rtl/mpu_poll_sequencer.sv
// Wakes the MPU-6050 once, then polls every axis at POLL_HZ.
// Define POLL_SEQ_TEMP_EN to include the TEMP read (index 3) per frame.
module mpu_poll_sequencer #(
  parameter int unsigned FPGA_CLK      = 50_000_000,
  parameter int unsigned POLL_HZ       = 100,
  parameter logic [7:0]  INSTR_INIT    = 8'h01,
  parameter logic [7:0]  INSTR_RD_BASE = 8'h10,
  parameter int unsigned BUSY_TO       = 1024,
  parameter int unsigned XFER_TO       = 50_000
) (
  input  logic                 CLK,
  input  logic                 RST_n,
  input  logic                 I_START,
  mpu_poll_sequencer_if.master io_ctl,
  output logic [15:0]          O_AX,
  output logic [15:0]          O_AY,
  output logic [15:0]          O_AZ,
  output logic [15:0]          O_TEMP,
  output logic [15:0]          O_GX,
  output logic [15:0]          O_GY,
  output logic [15:0]          O_GZ,
  output logic                 O_VALID,
  output logic                 O_INIT_DONE,
  output logic [7:0]           O_ERR_CNT
);
  localparam logic [31:0] PER_LAST =
    32'(FPGA_CLK / POLL_HZ) - 32'd1;
  localparam logic [31:0] BUSY_LIM = 32'(BUSY_TO);
  localparam logic [31:0] XFER_LIM = 32'(XFER_TO);
  localparam logic [2:0]  IDX_LAST = 3'd6;
`ifdef POLL_SEQ_TEMP_EN
  localparam bit TEMP_EN = 1'b1;
`else
  localparam bit TEMP_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT_HI,
    S_WAIT_LO,
    S_STORE,
    S_WAIT_PERIOD
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [2:0]  r_idx;
  logic [2:0]  w_idx_d;
  logic [2:0]  w_idx_inc;
  logic        r_init_done;
  logic        w_init_d;
  logic [31:0] r_per_cnt;
  logic [31:0] r_to;
  logic        r_hi_seen;
  logic        r_fail;
  logic        w_fail;
  logic [7:0]  r_instr;
  logic [7:0]  r_err_cnt;
  logic        r_valid;
  logic [15:0] r_sh  [7];
  logic [15:0] r_out [7];
  logic        w_last;
  logic        w_per_done;
  logic        w_frame_start;
  logic        w_unused;

  assign w_unused      = &{1'b0, io_ctl.I_RXD[23:16]};
  assign w_last        = (r_idx == IDX_LAST);
  assign w_per_done    = (r_per_cnt >= PER_LAST);
  assign w_frame_start = (r_state == S_REQ) &&
                         (!r_init_done || r_idx == 3'd0);
  assign w_idx_inc     = (!TEMP_EN && r_idx == 3'd2) ?
                         3'd4 : r_idx + 3'd1;

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    w_fail   = 1'b0;
    w_idx_d  = r_idx;
    w_init_d = r_init_done;
    unique case (r_state)
      S_IDLE: begin
        if (I_START) w_next = S_REQ;
      end
      S_REQ: begin
        w_next = S_WAIT_HI;
      end
      S_WAIT_HI: begin
        if (io_ctl.I_BUSY || r_hi_seen) begin
          w_next = S_WAIT_LO;
        end else if (r_to > BUSY_LIM) begin
          w_next = S_STORE;
          w_fail = 1'b1;
        end
      end
      S_WAIT_LO: begin
        if (!io_ctl.I_BUSY) begin
          w_next = S_STORE;
          w_fail = io_ctl.I_ERR;
        end else if (r_to > XFER_LIM) begin
          w_next = S_STORE;
          w_fail = 1'b1;
        end
      end
      S_STORE: begin
        if (r_fail) begin
          w_next  = S_WAIT_PERIOD;
          w_idx_d = 3'd0;
        end else if (!r_init_done) begin
          w_init_d = 1'b1;
          w_next   = I_START ? S_REQ : S_IDLE;
        end else if (!w_last) begin
          w_idx_d = w_idx_inc;
          w_next  = S_REQ;
        end else begin
          w_idx_d = 3'd0;
          // an overrun frame restarts at once, no backlog
          if (!I_START)        w_next = S_IDLE;
          else if (w_per_done) w_next = S_REQ;
          else                 w_next = S_WAIT_PERIOD;
        end
      end
      S_WAIT_PERIOD: begin
        if (!I_START)        w_next = S_IDLE;
        else if (w_per_done) w_next = S_REQ;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      r_idx       <= 3'd0;
      r_init_done <= 1'b0;
      r_per_cnt   <= 32'd0;
      r_to        <= 32'd0;
      r_hi_seen   <= 1'b0;
      r_fail      <= 1'b0;
      r_instr     <= 8'h00;
      r_err_cnt   <= 8'h00;
      r_valid     <= 1'b0;
      for (int i = 0; i < 7; i++) begin
        r_sh[i]  <= 16'h0;
        r_out[i] <= 16'h0;
      end
    end else begin
      r_idx       <= w_idx_d;
      r_init_done <= w_init_d;
      r_valid     <= 1'b0;
      if (w_frame_start)
        r_per_cnt <= 32'd1;
      else if (r_per_cnt < PER_LAST)
        r_per_cnt <= r_per_cnt + 32'd1;
      if (r_state == S_REQ ||
          (r_state == S_WAIT_HI && w_next == S_WAIT_LO))
        r_to <= 32'd1;
      else if (r_to != '1)
        r_to <= r_to + 32'd1;
      if (r_state == S_REQ) r_hi_seen <= io_ctl.I_BUSY;
      if (w_next == S_STORE) r_fail <= w_fail;
      if (w_next == S_REQ)
        r_instr <= w_init_d ?
          INSTR_RD_BASE + {5'd0, w_idx_d} : INSTR_INIT;
      if (r_state == S_STORE) begin
        if (r_fail) begin
          if (r_err_cnt != 8'hFF) r_err_cnt <= r_err_cnt + 8'd1;
        end else if (r_init_done) begin
          r_sh[r_idx] <= io_ctl.I_RXD[15:0];
          // the final word bypasses its shadow so the frame lands whole
          if (w_last) begin
            for (int i = 0; i < 6; i++) r_out[i] <= r_sh[i];
            r_out[6] <= io_ctl.I_RXD[15:0];
            r_valid  <= 1'b1;
          end
        end
      end
    end
  end

  assign io_ctl.O_EN    = (r_state == S_REQ);
  assign io_ctl.O_INSTR = r_instr;
  assign O_AX           = r_out[0];
  assign O_AY           = r_out[1];
  assign O_AZ           = r_out[2];
  assign O_TEMP         = TEMP_EN ? r_out[3] : 16'h0;
  assign O_GX           = r_out[4];
  assign O_GY           = r_out[5];
  assign O_GZ           = r_out[6];
  assign O_VALID        = r_valid;
  assign O_INIT_DONE    = r_init_done;
  assign O_ERR_CNT      = r_err_cnt;
endmodule

// File: doc/mpu_poll_sequencer.md
# mpu_poll_sequencer

Autonomous polling master for the MPU-6050 I2C controller (`top_mpu_6050`). It replaces the manual key/switch instruction entry with a periodic, timed instruction stream. It issues one wake-up instruction after reset, then reads every sensor axis at a fixed rate and latches each received word into per-axis registers. It sits directly upstream of the controller (drives its enable and instruction inputs) and consumes the controller's receive buffer, busy and error outputs.

## Interface
Parameters:
- FPGA_CLK, 50_000_000, clock frequency in Hz
- POLL_HZ, 100, frame rate in Hz; period = FPGA_CLK/POLL_HZ cycles
- INSTR_INIT, 8'h01, wake-up instruction (PWR_MGMT_1 write)
- INSTR_RD_BASE, 8'h10, instruction for read index 0; index k uses INSTR_RD_BASE+k
- BUSY_TO, 1024, max cycles from request to I_BUSY rising
- XFER_TO, 50_000, max cycles I_BUSY may stay high

Ports:
- CLK  in  1  system clock
- RST_n  in  1  asynchronous, active-low reset
- I_START  in  1  level; high enables polling
- I_BUSY  in  1  controller busy
- I_ERR  in  1  controller NACK/error, sampled when I_BUSY falls
- I_RXD  in  24  controller receive buffer; [15:8] high byte, [7:0] low byte
- O_EN  out  1  one-cycle request pulse to controller
- O_INSTR  out  8  instruction; valid while O_EN high and held until I_BUSY falls
- O_AX, O_AY, O_AZ, O_TEMP, O_GX, O_GY, O_GZ  out  16 each  latest samples (two's complement)
- O_VALID  out  1  one-cycle pulse when a complete frame is latched
- O_INIT_DONE  out  1  high once wake-up succeeded
- O_ERR_CNT  out  8  saturating error counter

## Operation
- Read index map: 0 AX, 1 AY, 2 AZ, 3 TEMP, 4 GX, 5 GY, 6 GZ.
- FSM states:
  - IDLE: wait for I_START.
  - REQ: O_EN=1 for one cycle.
  - WAIT_HI: wait for I_BUSY=1; exceeding BUSY_TO is an error.
  - WAIT_LO: wait for I_BUSY=0; exceeding XFER_TO is an error.
  - STORE: act on the completed transfer.
  - WAIT_PERIOD: wait for the period counter to expire.
- First request after reset is INSTR_INIT. On success, O_INIT_DONE is set. On error, INIT retries after one period.
- STORE on a read: shadow[idx] <= I_RXD[15:0]; idx advances. After the last index, all shadows copy to the outputs in one cycle and O_VALID pulses. Outputs therefore always hold a coherent frame.
- Error (I_ERR=1 at busy fall, or either timeout): the partial frame is discarded, O_ERR_CNT increments (saturates at 255), idx resets to 0, and the FSM goes to WAIT_PERIOD.
- I_START low mid-frame: the current frame completes, then IDLE. I_START high again: the next frame starts immediately. INIT is not repeated.

## Timing
- Reset values: every output is 0, the FSM is in IDLE, idx=0, and the period counter is 0.
- O_EN rises 1 cycle after the FSM leaves IDLE/WAIT_PERIOD. O_INSTR is updated in the same cycle.
- Sample capture happens 1 cycle after I_BUSY is seen low. O_VALID and the output update happen on that same STORE cycle for the last index.
- Next REQ within a frame follows 1 cycle after STORE.
- The period counter restarts at the first REQ of each frame. If the frame exceeds the period, the next frame starts on the cycle after STORE (no skipped period accumulation).
- I_BUSY already high in REQ counts as risen on the next cycle.
- Reset asserted mid-transfer: the FSM aborts immediately. After release, INIT is reissued.

## Configuration
- POLL_SEQ_TEMP_EN defined: 7 reads per frame, including index 3; O_TEMP is updated.
- Undefined: 6 reads per frame, index 3 skipped (2→4), O_TEMP constant 0.

## Test plan
- Reset, I_START=1, controller model acks everything → first O_INSTR=8'h01, then 8'h10..8'h16. Checks: O_INIT_DONE=1, O_VALID single pulse, O_AX..O_GZ equal the model words.
- Model returns I_RXD=24'h00_ABCD for AZ → O_AZ=16'hABCD after O_VALID; other outputs unchanged until the frame completes.
- I_ERR=1 on GX → no O_VALID, O_ERR_CNT=1, outputs keep the previous frame, next frame starts at 8'h10 after one period.
- Model never raises I_BUSY → error after BUSY_TO+1 cycles, O_ERR_CNT increments. Repeated 300 times → O_ERR_CNT=255.
- With POLL_HZ chosen so period=2000 cycles, two frames → consecutive REQs for index 0 are exactly 2000 cycles apart.
- Build without POLL_SEQ_TEMP_EN → instruction 8'h13 never issued, O_TEMP=0.
